data_req_sender: RTL and testbench
==================================

// Module: data_req_sender
// PURPOSE
//  Source-side stage of the req/data four-phase handshake feeding the clk_2 averager.
//  Accepts 4-bit samples on a valid/ready port in the clk_1 domain and buffers them in a small FIFO.
//  Sends each sample across the clock boundary with a four-phase req/ack handshake.
//  Counts completed transfers in groups of 4, matching the averager's 4-sample window.
// PARAMETERS
//  DATA_W      4  sample width (in_data, data)
//  FIFO_DEPTH  4  input buffer entries; power of 2, >=2
//  SYNC_STAGES 2  flops in the ack synchronizer; >=2
// PORTS
//  clk_1      in   1       sender clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       upstream sample valid
//  in_data    in   DATA_W  upstream sample
//  in_ready   out  1       FIFO can accept; = !full, forced 0 while reset=1
//  ack        in   1       consumer's echo of req, asynchronous to clk_1
//  req        out  1       registered handshake request
//  data       out  DATA_W  registered sample; stable whenever req=1 or ack_s=1
//  busy       out  1       FSM not IDLE or FIFO non-empty
//  xfer_done  out  1       1-cycle pulse per completed four-phase transfer
//  group_cnt  out  2       completed transfers mod 4
//  group_done out  1       1-cycle pulse when transfer #4 of a group completes
// BEHAVIOUR
//  Reset (sync): req=0, data=0, FIFO empty, sync flops=0, state=IDLE.
//   Also xfer_done=0, group_done=0, group_cnt=0, in_ready=0 during reset.
//  Push: in_valid & in_ready at an edge writes in_data at wr_ptr; in_valid when full is ignored.
//   No data loss: in_ready is low when full.
//  ack_s: last stage of the SYNC_STAGES flop chain on ack; the FSM uses only ack_s.
//  FSM states and transitions:
//   IDLE: if FIFO non-empty & ack_s=0, at the edge: data<=head, pop, req<=1, ->WAIT_ACK.
//   WAIT_ACK: hold req=1 and data; when ack_s=1, req<=0, ->WAIT_REL.
//   WAIT_REL: hold data; when ack_s=0, ->IDLE, xfer_done<=1, group_cnt<=group_cnt+1.
//    If group_cnt was 3, also group_done<=1; group_cnt wraps 3->0.
//  Latency: sample pushed at edge N into an empty FIFO with FSM in IDLE -> req=1 after edge N+1.
//   Next launch comes no earlier than 1 cycle after returning to IDLE, so req is low at least 1 cycle.
//  data changes only at a launch edge, never while req=1 or ack_s=1.
//  Simultaneous push and pop in the same cycle is allowed; count is unchanged.
//   A push into a full FIFO cannot coincide with a pop (in_ready low).
//  Pointers: log2(FIFO_DEPTH)+1 bits; wrap-around is natural.
//   full = MSBs differ & LSBs equal; empty = pointers equal.
//  ack high in IDLE (stale or early): no launch until ack_s=0.
//  ack glitch low during WAIT_ACK before ack_s=1: no effect.
//  Reset mid-handshake: req drops on the reset edge and the in-flight sample is discarded.
//   FIFO contents are flushed; the consumer sees a normal release.
//  group_cnt counts only completed transfers; an aborted transfer is not counted.
// TESTING
//  T1 reset: hold reset 3 cycles, ack=0 -> req=0, data=0, in_ready=0, then in_ready=1 after release.
//  T2 single: push 4'hA, ack loopback req delayed 3 clk_1 -> req rises 1 edge after push, data=A.
//   Expected: req falls after ack_s=1, xfer_done pulses once, group_cnt=1.
//  T3 group: push 3,5,7,9 back-to-back, loopback ack -> data sequence 3,5,7,9 in order.
//   Expected: 4 xfer_done pulses, group_done pulses with the 4th, group_cnt=0.
//  T4 full: ack tied 0, push 6 samples -> one launched, 4 buffered, in_ready=0.
//   Expected: 6th sample held off upstream; release ack -> remaining samples delivered in order.
//  T5 stale ack: ack=1 at reset release, push 4'h2 -> req stays 0 until ack_s=0, then launches data=2.
//  T6 abort: assert reset while in WAIT_ACK -> req=0 next edge, FIFO empty, group_cnt=0.
//   Expected: no xfer_done pulse.

Source files
------------

// File: rtl/data_req_sender.sv
// Source side of a four-phase req/ack crossing: buffers upstream samples in a small FIFO,
// launches one per handshake, and counts completed transfers in groups of four.
module data_req_sender #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk_1,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_ack,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_xfer_done,
    output logic [1:0]        o_group_cnt,
    output logic              o_group_done
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRel} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_req;
    logic [DATA_W-1:0]      r_data;
    logic                   r_xfer_done;
    logic                   r_group_done;
    logic [1:0]             r_group_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_launch;
    logic w_drop_req;
    logic w_done;
    logic w_ack_s;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_in_ready = !w_full && !i_reset;
    assign w_push     = i_in_valid && o_in_ready;
    assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk_1) begin
        if (i_reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    always_ff @(posedge i_clk_1) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk_1) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk_1) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_drop_req   = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A stale ack from the consumer blocks the next launch until it clears.
                if (!w_empty && !w_ack_s) begin
                    w_launch     = 1'b1;
                    w_state_next = StWaitAck;
                end
            end
            StWaitAck: begin
                if (w_ack_s) begin
                    w_drop_req   = 1'b1;
                    w_state_next = StWaitRel;
                end
            end
            StWaitRel: begin
                if (!w_ack_s) begin
                    w_done       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_1) begin
        if (i_reset) begin
            r_req        <= 1'b0;
            r_data       <= '0;
            r_xfer_done  <= 1'b0;
            r_group_done <= 1'b0;
            r_group_cnt  <= 2'd0;
        end else begin
            if (w_launch) begin
                r_req  <= 1'b1;
                r_data <= r_mem[r_rd_ptr[AW-1:0]];
            end else if (w_drop_req) begin
                r_req <= 1'b0;
            end
            r_xfer_done  <= w_done;
            r_group_done <= w_done && (r_group_cnt == 2'd3);
            if (w_done) begin
                r_group_cnt <= r_group_cnt + 2'd1;
            end
        end
    end

    assign o_req        = r_req;
    assign o_data       = r_data;
    assign o_busy       = (r_state != StIdle) || !w_empty;
    assign o_xfer_done  = r_xfer_done;
    assign o_group_done = r_group_done;
    assign o_group_cnt  = r_group_cnt;

endmodule

// File: tb/tb_data_req_sender.sv
// Bench for data_req_sender: a consumer model echoes req as ack after a delay, and a scoreboard
// queue of accepted samples is compared against each launched sample.
module tb_data_req_sender;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready;
    logic       ack;
    logic       req;
    logic [3:0] data;
    logic       busy;
    logic       xfer_done;
    logic [1:0] group_cnt;
    logic       group_done;

    logic       ack_man = 1'b0;
    logic       lb_en = 1'b0;
    logic [2:0] lb_pipe = 3'b000;

    int checks = 0;
    int errors = 0;
    int xfer_seen = 0;
    int group_seen = 0;
    int group_at = 0;
    logic [3:0] exp_q[$];
    logic       prev_req = 1'b0;
    logic [3:0] prev_data = 4'h0;

    always #5 clk = ~clk;

    // Consumer model: ack follows req three clk_1 cycles later when loopback is enabled.
    always @(negedge clk) lb_pipe = {lb_pipe[1:0], req};
    assign ack = lb_en ? lb_pipe[2] : ack_man;

    data_req_sender #(
        .DATA_W     (4),
        .FIFO_DEPTH (4),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk_1     (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_ack       (ack),
        .o_req       (req),
        .o_data      (data),
        .o_busy      (busy),
        .o_xfer_done (xfer_done),
        .o_group_cnt (group_cnt),
        .o_group_done(group_done)
    );

    // Monitor: each req rising edge pops the scoreboard; data must hold while req is high.
    always @(negedge clk) begin
        if (!reset) begin
            if (req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch_order: launched data=%h, required no launch (queue empty)",
                             data);
                end else begin
                    logic [3:0] exp_d;
                    exp_d = exp_q.pop_front();
                    if (data !== exp_d) begin
                        errors++;
                        $display("FAIL launch_data: got %h, required %h", data, exp_d);
                    end
                end
            end
            if (req && prev_req) begin
                checks++;
                if (data !== prev_data) begin
                    errors++;
                    $display("FAIL data_stable: got %h, required %h", data, prev_data);
                end
            end
            if (xfer_done) xfer_seen++;
            if (group_done) begin
                group_seen++;
                group_at = xfer_seen;
            end
        end
        prev_req  = req;
        prev_data = data;
    end

    task automatic do_reset(input logic ack_during);
        @(negedge clk);
        reset   = 1'b1;
        lb_en   = 1'b0;
        ack_man = ack_during;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        xfer_seen  = 0;
        group_seen = 0;
        group_at   = 0;
    endtask

    task automatic push_one(input logic [3:0] d, output bit accepted);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        accepted = in_ready;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic push_wait(input logic [3:0] d, output bit accepted);
        int n;
        n = 0;
        accepted = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            accepted = 1'b1;
            exp_q.push_back(d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((busy || req || ack) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b req=%0b after %0d cycles, required idle", name, busy,
                     req, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counts(input string name, input int exp_x, input int exp_g,
                                input logic [1:0] exp_cnt);
        checks++;
        if (xfer_seen != exp_x) begin
            errors++;
            $display("FAIL %s_xfer_done: got %0d pulses, required %0d", name, xfer_seen, exp_x);
        end
        checks++;
        if (group_seen != exp_g) begin
            errors++;
            $display("FAIL %s_group_done: got %0d pulses, required %0d", name, group_seen, exp_g);
        end
        checks++;
        if (group_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_group_cnt: got %0d, required %0d", name, group_cnt, exp_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_delivered: %0d samples undelivered, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ack_man = 1'b0;
        lb_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req, data, in_ready, busy, xfer_done, group_done, group_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b data=%h in_ready=%b busy=%b xd=%b gd=%b gc=%0d, required all 0",
                     req, data, in_ready, busy, xfer_done, group_done, group_cnt);
        end
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit acc;
        do_reset(1'b0);
        lb_en = 1'b1;
        push_one(4'hA, acc);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: req=%b one edge after push edge... got early, required 0",
                     req);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || data !== 4'hA) begin
            errors++;
            $display("FAIL single_launch: req=%b data=%h, required req=1 data=a", req, data);
        end
        wait_idle("single");
        check_counts("single", 1, 0, 2'd1);
    endtask

    task automatic test_group();
        bit acc;
        logic [3:0] vals [4];
        vals = '{4'h3, 4'h5, 4'h7, 4'h9};
        do_reset(1'b0);
        lb_en = 1'b1;
        foreach (vals[i]) begin
            push_one(vals[i], acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL group_accept: sample %0d in_ready=0, required 1", i);
            end
        end
        wait_idle("group");
        check_counts("group", 4, 1, 2'd0);
        checks++;
        if (group_at != 4) begin
            errors++;
            $display("FAIL group_done_timing: pulsed with transfer %0d, required 4", group_at);
        end
    endtask

    task automatic test_full();
        bit acc;
        bit exp_acc [6];
        exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            push_one(4'(4'h1 + i), acc);
            checks++;
            if (acc != exp_acc[i]) begin
                errors++;
                $display("FAIL full_accept: sample %0d accepted=%0b, required %0b", i, acc,
                         exp_acc[i]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || req !== 1'b1 || data !== 4'h1) begin
            errors++;
            $display("FAIL full_hold: in_ready=%b req=%b data=%h, required 0 1 1", in_ready, req,
                     data);
        end
        in_valid = 1'b0;
        lb_en = 1'b1;
        push_wait(4'h6, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL full_retry: sample 6 never accepted, required accepted");
        end
        wait_idle("full");
        check_counts("full", 6, 1, 2'd2);
    endtask

    task automatic test_stale_ack();
        bit acc;
        int n;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        push_one(4'h2, acc);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req !== 1'b0) begin
                errors++;
                $display("FAIL stale_hold: req=%b with ack high, required 0", req);
            end
        end
        ack_man = 1'b0;
        lb_en = 1'b1;
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL stale_launch: req=%b after ack release, required 1", req);
        end
        wait_idle("stale");
        check_counts("stale", 1, 0, 2'd1);
    endtask

    task automatic test_abort();
        bit acc;
        int n;
        do_reset(1'b0);
        push_one(4'h5, acc);
        push_one(4'h6, acc);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || busy !== 1'b0 || group_cnt !== 2'd0 || data !== 4'h0) begin
            errors++;
            $display("FAIL abort_state: req=%b busy=%b gc=%0d data=%h, required 0 0 0 0", req,
                     busy, group_cnt, data);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_counts("abort", 0, 0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_group();
        test_full();
        test_stale_ack();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
